uart_rx: RTL
============

# uart_rx

Asynchronous UART receiver for the pic16f-antastic, the receive-side counterpart of the existing USART transmitter. It oversamples the RX pin using the 16x capture strobe from the baud-rate generator and deframes 8- or 9-bit frames. Received bytes go into a 2-deep receive FIFO. The block exposes the RCSTA and RCREG special-function registers and raises the RCIF set-strobe. Synchronous receive (SREN) is unimplemented.

## Interface
Parameters:
- none; frame format is controlled at run time through RCSTA.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous reset, active-low: asserted when 0 and sampled on `clk` rising edge.
- `UART_RXD`  in  1  serial input pin; asynchronous to `clk`; idles high.
- `uart_rx_cap_en`  in  1  one-`clk` strobe at 16x the baud rate, driven by the baud-rate generator.
- `reg_data_in`  in  8  general data bus.
- `rcsta_reg_wr_en`  in  1  write RCSTA from `reg_data_in`.
- `rcsta_reg_out`  out  8  {SPEN, RX9, SREN=0, CREN, ADDEN, FERR, OERR, RX9D}.
- `rxreg_reg_rd_en`  in  1  one-cycle strobe that pops the FIFO head; the CPU samples `rxreg_reg_out` in the same cycle.
- `rxreg_reg_out`  out  8  FIFO head data; 0 when the FIFO is empty.
- `rxif_set_en`  out  1  high while the FIFO is non-empty; the CPU cannot clear it.

## Operation
- RCSTA write updates SPEN[7], RX9[6], CREN[4] and ADDEN[3]. SREN, FERR, OERR and RX9D are read-only.
- `UART_RXD` passes through a 2-flop synchronizer, giving `rxd_s`.
- The receiver runs only when SPEN=1, CREN=1 and OERR=0. Otherwise the FSM is held in IDLE.
- FSM states:
  - IDLE: on a tick with `rxd_s`=0, go to START and clear `tick_cnt` to 0.
  - START: at the sample point (below), if the sampled bit is 1 it is a false start; return to IDLE. If it is 0, go to DATA.
  - DATA: take 8 bits, LSB first, one per 16 ticks; `bit_cnt` runs 0..7. Then go to BIT9 if RX9=1, else to STOP.
  - BIT9: take the 9th bit, then go to STOP.
  - STOP: sample the stop bit, push the frame (see below), then go to IDLE. The FSM re-arms in the same cycle, so back-to-back frames with a single stop bit are received.
- `tick_cnt`:
  - 4-bit counter that advances on each `uart_rx_cap_en`.
  - Wraps 15→0; the bit boundary is at the wrap.
  - The sample point is `tick_cnt`==7.
- FIFO entry = {ferr, bit9, data[7:0]}; ferr is set when the stop bit sampled 0. The FIFO depth is 2.
- ADDEN filter: when RX9=1 and ADDEN=1, frames with bit9=0 are dropped silently and are not pushed. ADDEN is ignored when RX9=0.
- Push into a full FIFO:
  - Set OERR and discard the new frame.
  - The FIFO contents are kept.
  - Reception halts until CREN is written 0.
- Pop and push in the same cycle: the pop is processed first. A full FIFO therefore accepts the push, and no overrun occurs.
- Pop from an empty FIFO: no effect.
- FERR and RX9D always reflect the head entry. Both read 0 when the FIFO is empty.
- Writing CREN=0:
  - Clears OERR.
  - Aborts any frame in progress (FSM to IDLE, counters to 0).
  - The FIFO is retained.
- Writing SPEN=0 does everything CREN=0 does, and also flushes the FIFO.

## Timing
- Reset values:
  - RCSTA = 8'h00.
  - FIFO empty.
  - `rxreg_reg_out` = 0 and `rxif_set_en` = 0.
  - FSM in IDLE; `tick_cnt` and `bit_cnt` = 0.
- Input latency: 2 `clk` cycles from the `UART_RXD` pin to `rxd_s`.
- Push happens on the `clk` edge of the STOP sample tick. `rxif_set_en`, `rxreg_reg_out`, FERR and RX9D show the new head on the following cycle.
- Pop: the FIFO advances on the edge of the `rxreg_reg_rd_en` cycle. The next head, or 0, is visible the following cycle.
- RCSTA write takes effect on the next edge. A write takes priority over a hardware OERR set in the same cycle.
- Reset mid-frame: everything returns to reset values, and the partial frame is lost.

## Configuration
- `UART_RX_MAJORITY_EN` defined:
  - Each bit value is the 2-of-3 majority of `rxd_s` at `tick_cnt` 6, 7 and 8.
  - The decision and any state transition happen at the tick where `tick_cnt`==8.
  - Push timing moves one tick later.
- Undefined: each bit is a single sample at `tick_cnt`==7.

## Test plan
- 8-bit frame 0xA5 with a valid stop bit, SPEN=CREN=1 → `rxreg_reg_out`=0xA5, `rxif_set_en`=1, FERR=0. A pop then gives `rxif_set_en`=0 and `rxreg_reg_out`=0.
- RX9=1, frame 0x3C with bit9=1, then a frame with stop=0 → head RX9D=1, FERR=0. After a pop, the head shows FERR=1.
- Three frames 0x11, 0x22, 0x33 with no pops → OERR=1 and FIFO holds 0x11 then 0x22. A 4th frame is ignored. Write CREN=0 then CREN=1 → OERR=0 and reception resumes.
- 3-tick low glitch on `UART_RXD` while IDLE → FSM returns to IDLE and nothing is pushed.
- RX9=ADDEN=1, frames 0x55/bit9=0 and 0x80/bit9=1 → only 0x80 is pushed.
- `rst`=0 asserted mid-DATA → all outputs 0, and the next full frame is received correctly.

Source files
------------

// File: rtl/uart_rx_if.sv
// CPU-side register bus of the UART receiver: RCSTA write/read, RCREG pop/read and the RCIF strobe.
interface uart_rx_if;
    logic [7:0] reg_data_in;
    logic       rcsta_reg_wr_en;
    logic [7:0] rcsta_reg_out;
    logic       rxreg_reg_rd_en;
    logic [7:0] rxreg_reg_out;
    logic       rxif_set_en;

    modport master (
        output reg_data_in, rcsta_reg_wr_en, rxreg_reg_rd_en,
        input  rcsta_reg_out, rxreg_reg_out, rxif_set_en
    );

    modport slave (
        input  reg_data_in, rcsta_reg_wr_en, rxreg_reg_rd_en,
        output rcsta_reg_out, rxreg_reg_out, rxif_set_en
    );
endinterface

// File: rtl/uart_rx.sv
// Asynchronous UART receiver: 16x oversampling, 8/9-bit frames, 2-deep FIFO, RCSTA/RCREG registers.
// Optional macro UART_RX_MAJORITY_EN selects 2-of-3 majority sampling at ticks 6/7/8.
module uart_rx (
    input  logic      clk,
    input  logic      rst,
    input  logic      UART_RXD,
    input  logic      uart_rx_cap_en,
    uart_rx_if.slave  bus
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] BIT9  = 3'd3;
    localparam logic [2:0] STOP  = 3'd4;

`ifdef UART_RX_MAJORITY_EN
    localparam logic [3:0] SAMPLE_T = 4'd8;
`else
    localparam logic [3:0] SAMPLE_T = 4'd7;
`endif

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    logic       rxd_p0, rxd_p1, rxd_s;
    logic       spen, rx9, cren, adden, oerr;
    logic [2:0] state;
    logic [3:0] tick_cnt;
    logic [2:0] bit_cnt;
    logic [7:0] data_sr;
    logic       bit9;
    logic [9:0] fifo_e0, fifo_e1;
    logic [1:0] fifo_cnt;

    logic       wr, abort, flush, run, sample_pt, bit_val;
    logic       push, push_ok, pop, overrun;
    logic [1:0] cnt_after_pop;
    logic [9:0] new_entry, head;
    logic [7:0] wdata;
    logic       unused_wbits;

    assign wr    = bus.rcsta_reg_wr_en;
    assign wdata = bus.reg_data_in;
    assign unused_wbits = ^{wdata[5], wdata[2:0]};

    // A write that leaves SPEN or CREN low aborts the frame; SPEN low also flushes the FIFO.
    assign abort = wr & ~(wdata[7] & wdata[4]);
    assign flush = wr & ~wdata[7];
    assign run   = spen & cren & ~oerr;

    // Stage p0/p1: two-flop synchronizer for the asynchronous pin
    always_ff @(posedge clk) begin
        if (!rst) begin
            rxd_p0 <= 1'b1;
            rxd_p1 <= 1'b1;
        end else begin
            rxd_p0 <= UART_RXD;
            rxd_p1 <= rxd_p0;
        end
    end
    assign rxd_s = rxd_p1;

    assign sample_pt = uart_rx_cap_en && (tick_cnt == SAMPLE_T);

`ifdef UART_RX_MAJORITY_EN
    logic samp6, samp7;
    always_ff @(posedge clk) begin
        if (uart_rx_cap_en && tick_cnt == 4'd6) samp6 <= rxd_s;
        if (uart_rx_cap_en && tick_cnt == 4'd7) samp7 <= rxd_s;
    end
    assign bit_val = majority3(samp6, samp7, rxd_s);
`else
    assign bit_val = rxd_s;
`endif

    always_ff @(posedge clk) begin
        if (!rst || abort || !run) begin
            state    <= IDLE;
            tick_cnt <= 4'd0;
            bit_cnt  <= 3'd0;
        end else if (uart_rx_cap_en) begin
            tick_cnt <= tick_cnt + 4'd1;
            case (state)
                IDLE: begin
                    tick_cnt <= 4'd0;
                    if (!rxd_s) state <= START;
                end
                START: if (sample_pt) begin
                    if (bit_val) begin
                        state    <= IDLE;
                        tick_cnt <= 4'd0;
                    end else begin
                        state   <= DATA;
                        bit_cnt <= 3'd0;
                    end
                end
                DATA: if (sample_pt) begin
                    if (bit_cnt == 3'd7) begin
                        state   <= rx9 ? BIT9 : STOP;
                        bit_cnt <= 3'd0;
                    end else begin
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                end
                BIT9: if (sample_pt) state <= STOP;
                STOP: if (sample_pt) begin
                    state    <= IDLE;
                    tick_cnt <= 4'd0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (uart_rx_cap_en && state == DATA && tick_cnt == SAMPLE_T) data_sr <= {bit_val, data_sr[7:1]};
        if (uart_rx_cap_en && state == BIT9 && tick_cnt == SAMPLE_T) bit9 <= bit_val;
    end

    // Frames failing the address filter never reach the FIFO and cannot overrun it.
    assign new_entry     = {~bit_val, rx9 & bit9, data_sr};
    assign push          = run && !abort && state == STOP && sample_pt && !(rx9 && adden && !bit9);
    assign pop           = bus.rxreg_reg_rd_en && (fifo_cnt != 2'd0);
    assign cnt_after_pop = fifo_cnt - {1'b0, pop};
    assign overrun       = push && (cnt_after_pop == 2'd2);
    assign push_ok       = push && (cnt_after_pop != 2'd2);

    always_ff @(posedge clk) begin
        if (!rst || flush) fifo_cnt <= 2'd0;
        else               fifo_cnt <= cnt_after_pop + {1'b0, push_ok};
    end

    // Pop shifts the tail forward first; a later push write overrides the vacated slot.
    always_ff @(posedge clk) begin
        if (pop) fifo_e0 <= fifo_e1;
        if (push_ok) begin
            if (cnt_after_pop == 2'd0) fifo_e0 <= new_entry;
            else                       fifo_e1 <= new_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            spen  <= 1'b0;
            rx9   <= 1'b0;
            cren  <= 1'b0;
            adden <= 1'b0;
            oerr  <= 1'b0;
        end else if (wr) begin
            spen  <= wdata[7];
            rx9   <= wdata[6];
            cren  <= wdata[4];
            adden <= wdata[3];
            oerr  <= oerr & wdata[7] & wdata[4];
        end else if (overrun) begin
            oerr  <= 1'b1;
        end
    end

    assign head              = (fifo_cnt != 2'd0) ? fifo_e0 : 10'd0;
    assign bus.rxreg_reg_out = head[7:0];
    assign bus.rcsta_reg_out = {spen, rx9, 1'b0, cren, adden, head[9], oerr, head[8]};
    assign bus.rxif_set_en   = (fifo_cnt != 2'd0);
endmodule
